// File: rtl/seven_seg_mux_driver_if.sv
// Bundle between the result/BCD logic and the multiplexed seven-segment driver.
// The driver takes the slave modport; whatever feeds it takes master.
interface seven_seg_mux_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lz_en;
   logic [6:0]              seg_out;
   logic                    dp_out;
   logic [NUM_DIGITS-1:0]   an_out;
   logic                    frame_done;

   modport master (
      output load, digits_in, dp_in, blank_mask, lz_en,
      input  seg_out, dp_out, an_out, frame_done
   );

   modport slave (
      input  load, digits_in, dp_in, blank_mask, lz_en,
      output seg_out, dp_out, an_out, frame_done
   );
endinterface

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with shadow/active digit sets,
// dead time between slots and display updates that only take effect between frames.
module seven_seg_mux_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   seven_seg_mux_driver_if.slave bus
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [31:0] BLANK_U = BLANK_CYCLES;

   logic [CNT_W-1:0]        cnt_p0;
   logic [IDX_W-1:0]        idx_p0;
   logic [4*NUM_DIGITS-1:0] shd_digits, act_digits;
   logic [NUM_DIGITS-1:0]   shd_dp, act_dp, shd_blank, act_blank;
   logic                    shd_lz, act_lz, pending;

   logic [6:0]              seg_p1;
   logic                    dp_p1;
   logic [NUM_DIGITS-1:0]   an_p1;
   logic                    frame_done_p1;

   function automatic logic [6:0] decode_glyph(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] seg_pins(input logic [7:0] s);
      return (SEG_ACTIVE_LOW != 0) ? ~s : s;
   endfunction

   function automatic logic [NUM_DIGITS-1:0] an_pins(input logic [NUM_DIGITS-1:0] a);
      return (AN_ACTIVE_LOW != 0) ? ~a : a;
   endfunction

   logic                  boundary_p0, dead_p0, wrap_p0;
   logic [NUM_DIGITS-1:0] sup_p0, an_onehot_p0;
   logic [3:0]            cur_digit_p0;
   logic                  cur_dp_p0, cur_dark_p0;

   assign wrap_p0     = (cnt_p0 == CNT_W'(REFRESH_DIV - 1));
   assign boundary_p0 = wrap_p0 && (idx_p0 == IDX_W'(NUM_DIGITS - 1));
   assign dead_p0     = (32'(cnt_p0) < BLANK_U);

   // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      sup_p0     = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above & (act_digits[4*k +: 4] == 4'h0);
         sup_p0[k]  = act_lz & zero_above;
      end
   end

   always_comb begin
      cur_digit_p0 = '0;
      cur_dp_p0    = 1'b0;
      cur_dark_p0  = 1'b0;
      an_onehot_p0 = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_p0 == IDX_W'(k)) begin
            cur_digit_p0    = act_digits[4*k +: 4];
            cur_dp_p0       = act_dp[k];
            cur_dark_p0     = act_blank[k] | sup_p0[k];
            an_onehot_p0[k] = 1'b1;
         end
      end
   end

   // ---- p0 -> p1: scan state and display sets advance, pin outputs registered ----
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0          <= '0;
         idx_p0          <= '0;
         shd_digits      <= '0;
         shd_dp          <= '0;
         shd_blank       <= '0;
         shd_lz          <= 1'b0;
         act_digits      <= '0;
         act_dp          <= '0;
         act_blank       <= '0;
         act_lz          <= 1'b0;
         pending         <= 1'b0;
         {seg_p1, dp_p1} <= seg_pins(8'h00);
         an_p1           <= an_pins('0);
         frame_done_p1   <= 1'b0;
      end else begin
         if (wrap_p0) begin
            cnt_p0 <= '0;
            idx_p0 <= (idx_p0 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p0 + 1'b1;
         end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
         end

         // A load landing on the boundary bypasses the shadow so it is not a frame late.
         if (bus.load) begin
            shd_digits <= bus.digits_in;
            shd_dp     <= bus.dp_in;
            shd_blank  <= bus.blank_mask;
            shd_lz     <= bus.lz_en;
            if (boundary_p0) begin
               act_digits <= bus.digits_in;
               act_dp     <= bus.dp_in;
               act_blank  <= bus.blank_mask;
               act_lz     <= bus.lz_en;
               pending    <= 1'b0;
            end else begin
               pending    <= 1'b1;
            end
         end else if (boundary_p0 && pending) begin
            act_digits <= shd_digits;
            act_dp     <= shd_dp;
            act_blank  <= shd_blank;
            act_lz     <= shd_lz;
            pending    <= 1'b0;
         end

         {seg_p1, dp_p1} <= seg_pins((dead_p0 || cur_dark_p0) ? 8'h00
                                     : {decode_glyph(cur_digit_p0), cur_dp_p0});
         an_p1           <= an_pins(dead_p0 ? '0 : an_onehot_p0);
         frame_done_p1   <= boundary_p0;
      end
   end

   assign bus.seg_out    = seg_p1;
   assign bus.dp_out     = dp_p1;
   assign bus.an_out     = an_p1;
   assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Bench for seven_seg_mux_driver: two instances (plain and inverted segment pins)
// share stimulus; a negedge monitor scores every slot against queued expectations.
module tb_seven_seg_mux_driver;
   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        load;
   logic [15:0] digits;
   logic [3:0]  dpv, blank;
   logic        lz;

   seven_seg_mux_driver_if #(.NUM_DIGITS(ND)) bus0 ();
   seven_seg_mux_driver_if #(.NUM_DIGITS(ND)) bus1 ();

   assign bus0.load = load;  assign bus0.digits_in = digits;  assign bus0.dp_in = dpv;
   assign bus0.blank_mask = blank;  assign bus0.lz_en = lz;
   assign bus1.load = load;  assign bus1.digits_in = digits;  assign bus1.dp_in = dpv;
   assign bus1.blank_mask = blank;  assign bus1.lz_en = lz;

   seven_seg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
                          .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   seven_seg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
                          .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       chk_gap;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp, input logic g);
      exp_t e;
      e.an = an; e.seg = seg; e.dp = dp; e.chk_gap = g;
      sb.push_back(e);
   endtask

   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] dps, input logic g0);
      push(4'b1110, s0, dps[0], g0);
      push(4'b1101, s1, dps[1], 1'b1);
      push(4'b1011, s2, dps[2], 1'b1);
      push(4'b0111, s3, dps[3], 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic l);
      digits = d; dpv = p; blank = b; lz = l; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_fd();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (bus0.frame_done) seen = 1'b1;
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL fd_timeout got=0 exp=1 t=%0t", $time);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout got=%0d exp=0 t=%0t", sb.size(), $time);
         sb.delete();
      end
   endtask

   // Monitor: slot starts pop the scoreboard; also checks hold, slot length, dead gap, frame period.
   initial begin
      logic [3:0]  prev_an;
      logic [11:0] held;
      int          run_len, gap_len, fd_gap;
      bit          cur_chk, fd_valid, prev_fd;
      exp_t        e;
      prev_an = 4'hF; held = '0; run_len = 0; gap_len = 0; fd_gap = 0;
      cur_chk = 1'b0; fd_valid = 1'b0; prev_fd = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_an = 4'hF; run_len = 0; gap_len = 0; fd_gap = 0;
            cur_chk = 1'b0; fd_valid = 1'b0; prev_fd = 1'b0;
         end else begin
            fd_gap++;
            if (bus0.frame_done) begin
               if (fd_valid) chk("fd_period", fd_gap, RD*ND);
               chk("fd_width", {31'd0, prev_fd}, 0);
               fd_valid = 1'b1;
               fd_gap   = 0;
            end
            prev_fd = bus0.frame_done;

            if (bus0.an_out != 4'hF) begin
               if (prev_an == 4'hF) begin
                  chk("one_hot", $countones(~bus0.an_out), 1);
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     chk("an_out", {28'd0, bus0.an_out}, {28'd0, e.an});
                     chk("seg_dp", {24'd0, bus0.seg_out, bus0.dp_out}, {24'd0, e.seg, e.dp});
                     chk("inv_pins", {20'd0, bus1.an_out, bus1.seg_out, bus1.dp_out},
                         {20'd0, e.an, ~e.seg, ~e.dp});
                     if (e.chk_gap) chk("dead_len", gap_len, BC);
                     held    = {bus0.an_out, bus0.seg_out, bus0.dp_out};
                     cur_chk = 1'b1;
                  end else begin
                     cur_chk = 1'b0;
                  end
                  run_len = 0;
               end else if (cur_chk) begin
                  chk("slot_hold", {20'd0, bus0.an_out, bus0.seg_out, bus0.dp_out}, {20'd0, held});
               end
               run_len++;
               gap_len = 0;
            end else begin
               if (prev_an != 4'hF) begin
                  if (cur_chk) chk("active_len", run_len, RD - BC);
                  cur_chk = 1'b0;
                  run_len = 0;
               end
               gap_len++;
            end
            prev_an = bus0.an_out;
         end
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; digits = '0; dpv = '0; blank = '0; lz = 1'b0;
      repeat (3) tick();
      chk("rst_an0",  {28'd0, bus0.an_out}, 32'hF);
      chk("rst_seg0", {24'd0, bus0.seg_out, bus0.dp_out}, 32'h00);
      chk("rst_pin1", {20'd0, bus1.an_out, bus1.seg_out, bus1.dp_out}, 32'hFFF);
      chk("rst_fd",   {31'd0, bus0.frame_done}, 0);
      rst = 1'b0;
      tick();

      // Hex glyphs 12AF
      do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
      wait_fd();
      push_frame(7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000, 4'b0000, 1'b1);
      wait_drain();

      // Leading-zero suppression
      do_load(16'h0005, 4'b0000, 4'b0000, 1'b1);
      wait_fd();
      push_frame(7'b1011011, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000, 1'b1);
      wait_drain();
      do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
      wait_fd();
      push_frame(7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000, 1'b1);
      wait_drain();

      // Two loads mid-frame: current frame unchanged, last load wins next frame
      wait_fd();
      push_frame(7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000, 1'b1);
      do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
      repeat (2) tick();
      do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
      wait_drain();
      wait_fd();
      push_frame(7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101, 4'b0000, 1'b1);
      wait_drain();

      // Load exactly on the boundary cycle goes straight to the next frame
      wait_fd();
      repeat (RD*ND - 1) tick();
      digits = 16'h3333; dpv = '0; blank = '0; lz = 1'b0; load = 1'b1;
      tick();
      load = 1'b0;
      chk("bnd_fd", {31'd0, bus0.frame_done}, 1);
      push_frame(7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 4'b0000, 1'b1);
      wait_drain();

      // Blank mask and decimal points
      do_load(16'h3333, 4'b0101, 4'b0100, 1'b0);
      wait_fd();
      push_frame(7'b1111001, 7'b1111001, 7'b0000000, 7'b1111001, 4'b0001, 1'b1);
      wait_drain();

      // Reset during digit 2 with a load pending
      wait_fd();
      do_load(16'h7777, 4'b1111, 4'b0000, 1'b0);
      for (int i = 0; i < 100 && bus0.an_out != 4'b1011; i++) tick();
      chk("reach_d2", {28'd0, bus0.an_out}, 32'hB);
      rst = 1'b1;
      tick();
      chk("mid_rst_an",  {28'd0, bus0.an_out}, 32'hF);
      chk("mid_rst_seg", {24'd0, bus0.seg_out, bus0.dp_out}, 32'h00);
      chk("mid_rst_fd",  {31'd0, bus0.frame_done}, 0);
      push_frame(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000, 1'b0);
      push_frame(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000, 1'b1);
      rst = 1'b0;
      wait_drain();
      repeat (12) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seven_seg_mux_driver.md
Name: seven_seg_mux_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment bank showing the ALU result.
- Holds a shadow and an active digit register set, decodes each 4-bit digit to segments, and scans anodes at a programmable refresh rate.
- Adds features a single-digit decoder lacks: full hex glyphs, per-digit blanking, decimal points, leading-zero suppression, anti-ghost dead time and tear-free frame-synchronous updates.
- Sits between the ALU result/BCD conversion logic and the board pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (>=2).
- REFRESH_DIV, 1000: clock cycles per digit slot (>=2).
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV).
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out and dp_out at the pins.
- AN_ACTIVE_LOW, 1: 1 means an_out is asserted low.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- load, input, 1: single-cycle strobe; captures digits_in, dp_in, blank_mask and lz_en into the shadow registers.
- digits_in, input, 4*NUM_DIGITS: digit k is bits [4k+3:4k]; digit 0 is rightmost / least significant.
- dp_in, input, NUM_DIGITS: per-digit decimal point enable.
- blank_mask, input, NUM_DIGITS: 1 forces that digit dark, including its dp.
- lz_en, input, 1: enables leading-zero suppression.
- seg_out, output, 7: segments {a,b,c,d,e,f,g}, MSB = a.
- dp_out, output, 1: decimal point.
- an_out, output, NUM_DIGITS: anode/digit enables.
- frame_done, output, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - slot counter = 0, digit index = 0.
  - Shadow and active registers = 0; pending = 0; frame_done = 0.
  - seg_out and dp_out show "off" (all zeros, inverted if SEG_ACTIVE_LOW); an_out all inactive.
  - Reset mid-scan aborts the scan immediately and discards any pending load.
- Scan:
  - Slot counter counts 0..REFRESH_DIV-1, then wraps.
  - On each wrap the digit index advances 0,1,...,NUM_DIGITS-1,0.
- Frame boundary = the cycle where counter = REFRESH_DIV-1 and index = NUM_DIGITS-1. On that cycle:
  - frame_done is registered high for the next cycle only.
  - If pending=1, active <= shadow and pending <= 0.
- Load:
  - load=1 writes the shadow registers and sets pending=1.
  - Repeated loads before a boundary overwrite the shadow; the last load wins.
  - load on the boundary cycle itself: the new inputs go straight to active, pending stays 0.
  - Active data therefore changes only between frames; a partially updated frame is never displayed.
- Decode (active-high, before polarity), glyphs 0-F:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero suppression (lz_en=1 in active set):
  - Digit k (k>=1) is dark if digit k and all higher digits equal 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - A dp on a suppressed digit is also suppressed.
- Dark digit (blank_mask, suppression, or dead time): seg=0000000 and dp=0 before polarity.
  - A masked digit's anode still asserts outside dead time, with segments off.
- Dead time: while counter < BLANK_CYCLES, an_out is all inactive and seg/dp are off.
- Output timing:
  - All outputs are registered; they reflect the counter/index/active state of the previous cycle.
  - After reset release, digit 0's anode first asserts on rising edge BLANK_CYCLES+1 and stays asserted for REFRESH_DIV-BLANK_CYCLES cycles.
  - At most one anode is asserted in any cycle.

Test Plan:
- Params 4/8/2/0/1, rst then load digits_in=16'h12AF, dp_in=0, blank_mask=0, lz_en=0 -> after first frame_done, slots show an_out 1110,1101,1011,0111 with seg 1000111,1110111,1101101,0110000; each slot has 2 all-off cycles then 6 active cycles.
- load 16'h0005 with lz_en=1 -> digits 3..1 dark (anode asserted, seg 0000000), digit 0 shows 1011011; load 16'h0000 -> only digit 0 lit, showing 1111110.
- Two loads mid-frame (16'h1111, then 16'h2222) -> the current frame is unchanged; the next frame shows all 1101101; frame_done pulses exactly once per 32 cycles.
- load asserted exactly on the boundary cycle with 16'h3333 -> the very next slot (digit 0) shows 1111001.
- blank_mask=4'b0100, dp_in=4'b0101 -> digit 2 seg=0 and dp=0; digit 0 dp_out=1; with SEG_ACTIVE_LOW=1 all seg/dp values are inverted.
- rst asserted during digit 2 with a load pending -> next cycle all anodes inactive, index 0, digit 0 shows 1111110 (active=0) after dead time; the pending data never appears.
